activity_trace_writer: RTL and testbench

//  Samples toggle activity on NUM_NETS monitored cell-output nets over fixed windows.

---
 rtl/activity_trace_writer_pkg.sv | 32 +++
 rtl/activity_trace_writer_toggle_counter.sv | 38 +++
 rtl/activity_trace_writer.sv | 104 ++++++++++
 tb/tb_activity_trace_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/activity_trace_writer_pkg.sv
// Activity-trace record layout and FSM encoding shared by the writer
// and anything that reconstructs its records.
package activity_trace_pkg;

  localparam int DEF_NUM_NETS = 8;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_WINDOW   = 1024;
  localparam int DEF_SEQ_W    = 8;

  // Record is {seq, net_id, count}; count occupies the LSBs.
  localparam int CNT_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [63:0] rec_pack(
    input logic [31:0] seq,
    input logic [31:0] id,
    input logic [31:0] cnt,
    input int          id_w,
    input int          cnt_w
  );
    logic [63:0] r;
    r = {32'd0, seq};
    r = (r << id_w) | {32'd0, id};
    r = (r << cnt_w) | ({32'd0, cnt} << CNT_LSB);
    return r;
  endfunction

endpackage

// File: rtl/activity_trace_writer_toggle_counter.sv
// Per-net toggle detector with a saturating counter that reloads
// with the current toggle at the end of every sampling window.
module toggle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_net,
  input  logic             i_prime,
  input  logic             i_term,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tgl;

  assign w_tgl = i_prime & (i_net ^ r_prev);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_net;
      if (i_en) begin
        // A toggle on the terminal cycle opens the next window.
        if (i_term)
          r_cnt <= {{(CNT_W-1){1'b0}}, w_tgl};
        else if (w_tgl && r_cnt != '1)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/activity_trace_writer.sv
// Windowed toggle-activity sampler emitting one {seq, id, count}
// record per monitored net on a valid/ready stream.
module activity_trace_writer
  import activity_trace_pkg::*;
#(
  parameter int NUM_NETS = DEF_NUM_NETS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int SEQ_W    = DEF_SEQ_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_NETS-1:0] nets_i,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [SEQ_W+$clog2(NUM_NETS)+CNT_W-1:0] rec_data,
  output logic                overflow
);

  localparam int ID_W = $clog2(NUM_NETS);
  localparam int RW   = SEQ_W + ID_W + CNT_W;
  localparam int WC_W = $clog2(WINDOW);

  logic             r_prime;
  logic [WC_W-1:0]  r_wcnt;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_sseq;
  state_e           r_state;
  logic [ID_W-1:0]  r_idx;
  logic [CNT_W-1:0] r_shadow [NUM_NETS];
  logic             r_ovf;

  logic [CNT_W-1:0] w_cnt [NUM_NETS];
  logic             w_term;
  logic             w_acc;
  logic             w_last;

  for (genvar g = 0; g < NUM_NETS; g++) begin : g_tc
    toggle_counter #(.CNT_W(CNT_W)) u_tc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (en),
      .i_net   (nets_i[g]),
      .i_prime (r_prime),
      .i_term  (w_term),
      .o_cnt   (w_cnt[g])
    );
  end

  assign w_term = en && (r_wcnt == WC_W'(WINDOW - 1));
  assign w_acc  = (r_state == SEND) && rec_ready;
  assign w_last = (r_idx == ID_W'(NUM_NETS - 1));

  assign rec_valid = (r_state == SEND);
  assign overflow  = r_ovf;
  assign rec_data  = (r_state == SEND)
    ? RW'(rec_pack(32'(r_sseq), 32'(r_idx),
                   32'(r_shadow[r_idx]), ID_W, CNT_W))
    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= 1'b0;
      r_wcnt  <= '0;
      r_seq   <= '0;
      r_sseq  <= '0;
      r_state <= IDLE;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < NUM_NETS; k++)
        r_shadow[k] <= '0;
    end else begin
      r_prime <= 1'b1;
      if (w_term) begin
        r_wcnt <= '0;
        r_seq  <= r_seq + 1'b1;
      end else if (en) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_term) begin
            r_shadow <= w_cnt;
            r_sseq   <= r_seq;
            r_idx    <= '0;
            r_state  <= SEND;
          end
        end
        SEND: begin
          // Busy through the cycle of the last accept: snapshot lost.
          if (w_term)
            r_ovf <= 1'b1;
          if (w_acc) begin
            r_idx <= r_idx + 1'b1;
            if (w_last)
              r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_activity_trace_writer.sv
// Scoreboard bench for activity_trace_writer: a window/toggle model
// queues expected records, compared as the DUT presents them.
module tb_activity_trace_writer;
  import activity_trace_pkg::*;

  localparam int NN  = 8;
  localparam int CW  = 4;
  localparam int WIN = 16;
  localparam int SW  = 8;
  localparam int IW  = 3;
  localparam int RW  = SW + IW + CW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NN-1:0] nets;
  logic          rec_valid;
  logic          rec_ready;
  logic [RW-1:0] rec_data;
  logic          overflow;

  activity_trace_writer #(
    .NUM_NETS (NN),
    .CNT_W    (CW),
    .WINDOW   (WIN),
    .SEQ_W    (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .nets_i    (nets),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [NN-1:0] m_prev;
  bit            m_prime;
  int            m_live [NN];
  int            m_wcnt;
  int            m_seq;
  bit            m_ovf;
  bit            m_term;

  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] got_q [$];
  int            starts [$];
  int            cyc_n = 0;
  bit            prev_v = 1'b0;
  int            mark;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(int s, int id, int c);
    return RW'(rec_pack(32'(s), 32'(id), 32'(c), IW, CW));
  endfunction

  function automatic int count_seq(int s);
    int n = 0;
    foreach (got_q[i])
      if (int'(got_q[i][RW-1 -: SW]) == s) n++;
    return n;
  endfunction

  function automatic logic [RW-1:0] find(int s, int id);
    logic [RW-1:0] key;
    key = rec(s, id, 0) >> CW;
    foreach (got_q[i])
      if ((got_q[i] >> CW) == key) return got_q[i];
    return '1;
  endfunction

  task automatic model_reset();
    m_prev  = '0;
    m_prime = 1'b0;
    foreach (m_live[k]) m_live[k] = 0;
    m_wcnt  = 0;
    m_seq   = 0;
    m_ovf   = 1'b0;
    m_term  = 1'b0;
    exp_q.delete();
    prev_v  = 1'b0;
  endtask

  task automatic cyc(input bit e, input logic [NN-1:0] mask,
                     input bit rdy);
    bit busy;
    bit t;
    en        = e;
    nets      = nets ^ mask;
    rec_ready = rdy;
    busy = exp_q.size() != 0;
    if (busy && rdy) begin
      check("rec", 64'(rec_data), 64'(exp_q[0]));
      got_q.push_back(rec_data);
      void'(exp_q.pop_front());
    end
    m_term = e && (m_wcnt == WIN - 1);
    if (m_term && !busy)
      for (int k = 0; k < NN; k++)
        exp_q.push_back(rec(m_seq, k, m_live[k]));
    if (m_term && busy) m_ovf = 1'b1;
    for (int k = 0; k < NN; k++) begin
      t = m_prime && (nets[k] ^ m_prev[k]);
      if (e) begin
        if (m_term) m_live[k] = int'(t);
        else if (t && m_live[k] < CMAX) m_live[k]++;
      end
    end
    if (e) begin
      if (m_term) begin
        m_wcnt = 0;
        m_seq  = (m_seq + 1) % (1 << SW);
      end else begin
        m_wcnt++;
      end
    end
    m_prev  = nets;
    m_prime = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    check("valid", 64'(rec_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("hold", 64'(rec_data), 64'(exp_q[0]));
    check("ovf", 64'(overflow), 64'(m_ovf));
    if (rec_valid && !prev_v) starts.push_back(cyc_n);
    prev_v = rec_valid;
  endtask

  task automatic run(input int n, input bit e, input logic [NN-1:0] mask,
                     input bit rdy);
    for (int i = 0; i < n; i++) cyc(e, mask, rdy);
  endtask

  task automatic to_term(input logic [NN-1:0] mask, input bit rdy);
    int n = 0;
    do begin
      cyc(1'b1, mask, rdy);
      n++;
    end while (!m_term && n < 100);
    check("term_seen", 64'(m_term), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    nets = '0;
    rec_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(rec_valid), 64'd0);
    check("rst_data", 64'(rec_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // net0 toggles every cycle; the priming cycle has en low
    cyc(1'b0, 8'h01, 1'b1);
    to_term(8'h01, 1'b1);
    run(8, 1'b1, 8'h00, 1'b1);
    check("t1_net0", 64'(find(0, 0)), 64'(rec(0, 0, 15)));
    check("t1_net1", 64'(find(0, 1)), 64'(rec(0, 1, 0)));
    check("t1_count", 64'(count_seq(0)), 64'd8);

    // consumer stalls for 5 cycles mid-burst
    to_term(8'h00, 1'b1);
    run(3, 1'b1, 8'h00, 1'b1);
    run(5, 1'b1, 8'h00, 1'b0);
    run(5, 1'b1, 8'h00, 1'b1);
    check("t2_count", 64'(count_seq(1)), 64'd8);
    check("t2_net0", 64'(find(1, 0)), 64'(rec(1, 0, 1)));

    // net3 toggles past the 4-bit counter limit
    to_term(8'h08, 1'b1);
    to_term(8'h08, 1'b1);
    to_term(8'h00, 1'b1);
    run(8, 1'b1, 8'h00, 1'b1);
    check("t3_sat", 64'(find(3, 3)), 64'(rec(3, 3, 15)));
    check("t3_fresh", 64'(find(4, 3)), 64'(rec(4, 3, 1)));
    check("t3_net2", 64'(find(3, 2)), 64'(rec(3, 2, 0)));

    // ready held low across two terminal cycles
    to_term(8'h00, 1'b0);
    to_term(8'h00, 1'b0);
    check("t4_ovf", 64'(overflow), 64'd1);
    run(8, 1'b1, 8'h00, 1'b1);
    to_term(8'h00, 1'b1);
    run(8, 1'b1, 8'h00, 1'b1);
    check("t4_seq5", 64'(count_seq(5)), 64'd8);
    check("t4_seq6", 64'(count_seq(6)), 64'd0);
    check("t4_seq7", 64'(count_seq(7)), 64'd8);

    // toggle on the terminal cycle, then a 10-cycle en gap
    while (m_wcnt != WIN - 1) cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h01, 1'b1);
    run(5, 1'b1, 8'h00, 1'b1);
    run(10, 1'b0, 8'h00, 1'b1);
    to_term(8'h00, 1'b1);
    check("t5_old", 64'(find(8, 0)), 64'(rec(8, 0, 0)));
    run(1, 1'b1, 8'h00, 1'b1);
    check("t5_new", 64'(exp_q.size() == 7 ? got_q[got_q.size()-1] : '1),
          64'(rec(9, 0, 1)));
    check("t5_stretch",
          64'(starts[starts.size()-1] - starts[starts.size()-2]),
          64'(WIN + 10));

    // reset in the middle of a burst
    run(2, 1'b1, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(rec_valid), 64'd0);
    check("t6_data", 64'(rec_data), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nets = '0;
    model_reset();
    mark = got_q.size();
    cyc(1'b0, 8'h00, 1'b1);
    to_term(8'h00, 1'b1);
    run(8, 1'b1, 8'h00, 1'b1);
    check("t6_seq9", 64'(count_seq(9)), 64'd3);
    check("t6_first", 64'(got_q[mark]), 64'(rec(0, 0, 0)));
    check("t6_burst", 64'(got_q.size() - mark), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
